wb_stage: RTL

Write-back stage of the MIPS pipeline: the producer side of the register-file write port (rw5 / regWrite5 / Busw). Holds the MEM/WB pipeline register, waits for data-memory load responses through a valid handshake, aligns and extends load data, and issues exactly one register-file write per retired instruction. Sits between the MEM stage and the register file; back-pressures MEM while a load response is outstanding.

---
 rtl/wb_stage.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// wb_stage: MIPS write-back stage with a MEM/WB register, a load-response handshake and one register-file write per retired instruction.
// Defining WB_TIMEOUT_EN enables the load-wait watchdog that reports through err[2].
module wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rw,
  input  logic        mem_regWrite,
  input  logic        mem_memToReg,
  input  logic [2:0]  mem_loadType,
  input  logic [31:0] mem_aluResult,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  rw5,
  output logic        regWrite5,
  output logic [31:0] Busw,
  output logic [2:0]  err
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RW_W   = 5;
  localparam int unsigned LT_W   = 3;
  localparam int unsigned ERR_W  = 3;

  localparam logic [LT_W-1:0] LT_LB  = 3'd1;
  localparam logic [LT_W-1:0] LT_LBU = 3'd2;
  localparam logic [LT_W-1:0] LT_LH  = 3'd3;
  localparam logic [LT_W-1:0] LT_LHU = 3'd4;

  typedef enum logic [1:0] {
    S_EMPTY     = 2'd0,
    S_ALU_WB    = 2'd1,
    S_LOAD_WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [RW_W-1:0]   rw_q, rw_d;
  logic              regwr_q, regwr_d;
  logic [LT_W-1:0]   ltype_q, ltype_d;
  logic [1:0]        off_q, off_d;
  logic [RW_W-1:0]   rw5_q, rw5_d;
  logic              regwrite5_q, regwrite5_d;
  logic [DATA_W-1:0] busw_q, busw_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              accept;

`ifdef WB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^DATA_W'(TIMEOUT_CYCLES);
`endif

  // Big-endian byte/halfword selection with sign or zero extension.
  function automatic logic [DATA_W-1:0] fmt_load(input logic [LT_W-1:0] lt,
                                                 input logic [1:0] off,
                                                 input logic [DATA_W-1:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [DATA_W-1:0] r;
    case (off)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    h = off[1] ? d[15:0] : d[31:16];
    case (lt)
      LT_LB:   r = {{24{b[7]}}, b};
      LT_LBU:  r = {24'd0, b};
      LT_LH:   r = {{16{h[15]}}, h};
      LT_LHU:  r = {16'd0, h};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(input logic [LT_W-1:0] lt, input logic [1:0] off);
    logic m;
    case (lt)
      LT_LB, LT_LBU: m = 1'b0;
      LT_LH, LT_LHU: m = off[0];
      default:       m = (off != 2'd0);
    endcase
    return m;
  endfunction

  assign mem_ready = (state_q != S_LOAD_WAIT);
  assign accept    = mem_valid && mem_ready;

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    regwr_d     = regwr_q;
    ltype_d     = ltype_q;
    off_d       = off_q;
    rw5_d       = rw5_q;
    regwrite5_d = 1'b0;
    busw_d      = busw_q;
    err_d       = err_q;
`ifdef WB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      S_EMPTY, S_ALU_WB: begin
        if (dmem_rvalid) err_d[1] = 1'b1;
        if (accept) begin
          rw_d    = mem_rw;
          regwr_d = mem_regWrite;
          if (!mem_memToReg) begin
            state_d = S_ALU_WB;
            if (mem_regWrite && (mem_rw != '0)) begin
              regwrite5_d = 1'b1;
              rw5_d       = mem_rw;
              busw_d      = mem_aluResult;
            end
          end else begin
            state_d = S_LOAD_WAIT;
            ltype_d = mem_loadType;
            off_d   = mem_aluResult[1:0];
`ifdef WB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end else begin
          state_d = S_EMPTY;
        end
      end

      S_LOAD_WAIT: begin
        if (dmem_rvalid) begin
          state_d = S_EMPTY;
          if (misaligned(ltype_q, off_q)) begin
            err_d[0] = 1'b1;
          end else if (regwr_q && (rw_q != '0)) begin
            regwrite5_d = 1'b1;
            rw5_d       = rw_q;
            busw_d      = fmt_load(ltype_q, off_q, dmem_rdata);
          end
        end
`ifdef WB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d  = S_EMPTY;
          err_d[2] = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      default: state_d = S_EMPTY;
    endcase

`ifndef WB_TIMEOUT_EN
    err_d[2] = 1'b0;
`endif
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= S_EMPTY;
      rw_q        <= '0;
      regwr_q     <= 1'b0;
      ltype_q     <= '0;
      off_q       <= '0;
      rw5_q       <= '0;
      regwrite5_q <= 1'b0;
      busw_q      <= '0;
      err_q       <= '0;
`ifdef WB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      regwr_q     <= regwr_d;
      ltype_q     <= ltype_d;
      off_q       <= off_d;
      rw5_q       <= rw5_d;
      regwrite5_q <= regwrite5_d;
      busw_q      <= busw_d;
      err_q       <= err_d;
`ifdef WB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign rw5       = rw5_q;
  assign regWrite5 = regwrite5_q;
  assign Busw      = busw_q;
  assign err       = err_q;

endmodule
